// File: rtl/ifetch_unit_if.sv
// rtl/ifetch_unit_if.sv - control, instruction-memory and IF/ID signals of the fetch unit
// master: the fetch unit itself; slave: the pipeline/memory side that drives controls and data.
interface ifetch_unit_if;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        misalign_err;

    modport master (
        input  stall, branch_taken, branch_target, imem_data,
        output imem_addr, instr_out, pc_out, instr_valid, misalign_err
    );

    modport slave (
        output stall, branch_taken, branch_target, imem_data,
        input  imem_addr, instr_out, pc_out, instr_valid, misalign_err
    );
endinterface

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - PC register and IF/ID latch with stall, branch redirect and misalign flag
// Optional macro IFETCH_BRANCH_FLUSH_EN: squash the delay-slot word on a branch edge.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic          clk,
    input  logic          reset,
    ifetch_unit_if.master bus
);

    logic [31:0] pc;
    logic [31:0] instr_q;
    logic [31:0] pc_out_q;
    logic        valid_q;
    logic        err_q;

    assign bus.imem_addr    = pc;
    assign bus.instr_out    = instr_q;
    assign bus.pc_out       = pc_out_q;
    assign bus.instr_valid  = valid_q;
    assign bus.misalign_err = err_q;

    // A branch wins over stall; the IF/ID update on that edge depends on the delay-slot mode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc       <= {RESET_PC[31:2], 2'b00};
            instr_q  <= 32'h0;
            pc_out_q <= 32'h0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else if (bus.branch_taken) begin
            pc       <= {bus.branch_target[31:2], 2'b00};
            pc_out_q <= pc;
            if (bus.branch_target[1:0] != 2'b00) begin
                err_q <= 1'b1;
            end
`ifdef IFETCH_BRANCH_FLUSH_EN
            instr_q  <= 32'h0;
            valid_q  <= 1'b0;
`else
            instr_q  <= bus.imem_data;
            valid_q  <= 1'b1;
`endif
        end else if (!bus.stall) begin
            pc       <= pc + 32'd4;
            pc_out_q <= pc;
            instr_q  <= bus.imem_data;
            valid_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - directed table, corner sequences and randomized model check of ifetch_unit
module tb_ifetch_unit;

`ifdef IFETCH_BRANCH_FLUSH_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    ifetch_unit_if bus ();

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a == 32'h0) return 32'h180A0000;
        return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
    endfunction

    assign bus.imem_data = word_at(bus.imem_addr);

    ifetch_unit #(.RESET_PC(32'd0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference state: what the fetch stage should hold, derived from the fetch rules.
    logic [31:0] m_pc, m_instr, m_pc_out;
    logic        m_valid, m_err;

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_pc_out = 32'h0; m_valid = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_step(input logic s, input logic b, input logic [31:0] t);
        if (b) begin
            m_pc_out = m_pc;
            m_instr  = FLUSH ? 32'h0 : word_at(m_pc);
            m_valid  = !FLUSH;
            if (t % 4 != 0) m_err = 1'b1;
            m_pc = t - (t % 4);
        end else if (!s) begin
            m_pc_out = m_pc;
            m_instr  = word_at(m_pc);
            m_valid  = 1'b1;
            m_pc     = m_pc + 32'd4;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".imem_addr"},    bus.imem_addr,           m_pc);
        chk({tag, ".pc_out"},       bus.pc_out,              m_pc_out);
        chk({tag, ".instr_out"},    bus.instr_out,           m_instr);
        chk({tag, ".instr_valid"},  {31'd0, bus.instr_valid},  {31'd0, m_valid});
        chk({tag, ".misalign_err"}, {31'd0, bus.misalign_err}, {31'd0, m_err});
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".imem_addr"},    bus.imem_addr,                32'h0);
        chk({tag, ".pc_out"},       bus.pc_out,                   32'h0);
        chk({tag, ".instr_out"},    bus.instr_out,                32'h0);
        chk({tag, ".instr_valid"},  {31'd0, bus.instr_valid},  32'h0);
        chk({tag, ".misalign_err"}, {31'd0, bus.misalign_err}, 32'h0);
    endtask

    task automatic step(input logic s, input logic b, input logic [31:0] t);
        bus.stall = s; bus.branch_taken = b; bus.branch_target = t;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] target;
        logic [31:0] exp_addr;
        logic [31:0] exp_pc_out;
        logic        br_edge;
        logic        exp_err;
    } vec_t;

    vec_t vt[17];

    initial begin
        logic [31:0] r, t;
        logic        s, b;
        logic [31:0] e_instr;
        logic        e_valid;

        vt[0]  = '{0, 0, 32'h0,   32'd4,   32'd0,   0, 0};
        vt[1]  = '{0, 0, 32'h0,   32'd8,   32'd4,   0, 0};
        vt[2]  = '{0, 0, 32'h0,   32'd12,  32'd8,   0, 0};
        vt[3]  = '{0, 0, 32'h0,   32'd16,  32'd12,  0, 0};
        vt[4]  = '{1, 0, 32'h0,   32'd16,  32'd12,  0, 0};
        vt[5]  = '{1, 0, 32'h0,   32'd16,  32'd12,  0, 0};
        vt[6]  = '{0, 0, 32'h0,   32'd20,  32'd16,  0, 0};
        vt[7]  = '{0, 0, 32'h0,   32'd24,  32'd20,  0, 0};
        vt[8]  = '{0, 0, 32'h0,   32'd28,  32'd24,  0, 0};
        vt[9]  = '{0, 0, 32'h0,   32'd32,  32'd28,  0, 0};
        vt[10] = '{0, 1, 32'h90,  32'h90,  32'd32,  1, 0};
        vt[11] = '{0, 0, 32'h0,   32'h94,  32'h90,  0, 0};
        vt[12] = '{1, 1, 32'h24,  32'h24,  32'h94,  1, 0};
        vt[13] = '{0, 0, 32'h0,   32'h28,  32'h24,  0, 0};
        vt[14] = '{0, 1, 32'h93,  32'h90,  32'h28,  1, 1};
        vt[15] = '{0, 1, 32'h100, 32'h100, 32'h90,  1, 1};
        vt[16] = '{0, 1, 32'h200, 32'h200, 32'h100, 1, 1};

        bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = 32'h0;
        reset = 1'b1;
        #12;
        chk_reset_vals("reset");
        @(negedge clk); reset = 1'b0;

        foreach (vt[i]) begin
            step(vt[i].stall, vt[i].br, vt[i].target);
            e_valid = !(vt[i].br_edge && FLUSH);
            e_instr = e_valid ? word_at(vt[i].exp_pc_out) : 32'h0;
            chk($sformatf("tbl%0d.imem_addr", i), bus.imem_addr, vt[i].exp_addr);
            chk($sformatf("tbl%0d.pc_out", i),    bus.pc_out,    vt[i].exp_pc_out);
            chk($sformatf("tbl%0d.instr_out", i), bus.instr_out, e_instr);
            chk($sformatf("tbl%0d.valid", i),     {31'd0, bus.instr_valid},  {31'd0, e_valid});
            chk($sformatf("tbl%0d.err", i),       {31'd0, bus.misalign_err}, {31'd0, vt[i].exp_err});
        end

        // Wrap of PC+4 past the top of the address space.
        step(0, 1, 32'hFFFF_FFFC);
        chk("wrap.pre_addr", bus.imem_addr, 32'hFFFF_FFFC);
        step(0, 0, 32'h0);
        chk("wrap.addr",   bus.imem_addr, 32'h0);
        chk("wrap.pc_out", bus.pc_out,    32'hFFFF_FFFC);
        chk("wrap.instr",  bus.instr_out, word_at(32'hFFFF_FFFC));

        // Reset in the middle of a stalled branch cycle acts without a clock edge.
        bus.stall = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 32'h55;
        #2 reset = 1'b1;
        #1 chk_reset_vals("async_reset");
        @(negedge clk); reset = 1'b0;
        step(0, 0, 32'h0);
        chk("post_reset.pc_out", bus.pc_out,    32'h0);
        chk("post_reset.instr",  bus.instr_out, 32'h180A0000);
        chk("post_reset.addr",   bus.imem_addr, 32'd4);
        chk("post_reset.err",    {31'd0, bus.misalign_err}, 32'h0);

        // Randomized run against the reference model.
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        model_reset();
        for (int n = 0; n < 400; n++) begin
            s = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 4) == 0);
            r = $urandom;
            t = ($urandom_range(0, 9) == 0) ? r : (r & ~32'h3);
            if ($urandom_range(0, 99) < 3 && !b) t = 32'hFFFF_FFFC;
            step(s, b, t);
            model_step(s, b, t);
            chk_model($sformatf("rnd%0d", n));
            if ($urandom_range(0, 59) == 0) begin
                #2 reset = 1'b1;
                #1 reset = 1'b0;
                model_reset();
                chk_model($sformatf("rnd%0d.rst", n));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'd0, PC value loaded on reset; bits [1:0] SHALL be zero.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port stall, input, 1 bit: when high, hold PC and the IF/ID register.
REQ-005 Port branch_taken, input, 1 bit: redirect fetch to branch_target.
REQ-006 Port branch_target, input, 32 bits: byte address of the redirect.
REQ-007 Port imem_addr, output, 32 bits: byte address presented to instruction memory.
REQ-008 Port imem_data, input, 32 bits: word returned combinationally for imem_addr.
REQ-009 Port instr_out, output, 32 bits: IF/ID instruction register.
REQ-010 Port pc_out, output, 32 bits: address of instr_out.
REQ-011 Port instr_valid, output, 1 bit: instr_out holds a fetched (non-flushed) word.
REQ-012 Port misalign_err, output, 1 bit: sticky flag, set by a misaligned branch_target.

Function
REQ-013 imem_addr SHALL equal the PC register combinationally, with zero latency.
REQ-014 Memory is treated as read-only; the unit SHALL never drive write enables and SHALL always present word-aligned addresses.
REQ-015 When stall=0 and branch_taken=0, each edge: instr_out<=imem_data, pc_out<=PC, instr_valid<=1, PC<=PC+4.
REQ-016 PC+4 SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 32'h0) with no flag.
REQ-017 When stall=1 and branch_taken=0: PC, instr_out, pc_out and instr_valid SHALL hold.
REQ-018 When branch_taken=1, PC<={branch_target[31:2],2'b00} at the next edge, regardless of stall (branch has priority).
REQ-019 When branch_taken=1 and branch_target[1:0]!=0, misalign_err SHALL be set; it clears only on reset.
REQ-020 When branch_taken=1, the IF/ID update on that edge SHALL follow REQ-029/REQ-030.
REQ-021 A branch_taken asserted in consecutive cycles SHALL use the latest target each cycle.
REQ-022 State (conceptual): RUN, where PC advances; HOLD (stall); REDIRECT (branch edge). No other states exist; every state returns to RUN on the next un-stalled, non-branch cycle.

Reset
REQ-023 While reset=1, asynchronously: PC=RESET_PC, instr_out=32'h0, pc_out=32'h0, instr_valid=0, misalign_err=0.
REQ-024 Reset asserted mid-stall or mid-branch SHALL override all other inputs immediately.
REQ-025 The first edge after reset deasserts with stall=0 SHALL fetch from RESET_PC.

Configuration
REQ-026 Macro IFETCH_BRANCH_FLUSH_EN selects the delay-slot handling.
REQ-027 With the macro defined: on a branch edge, instr_out<=32'h0 (NOP), instr_valid<=0, and pc_out<=PC.
REQ-028 Without the macro: on a branch edge, the delay-slot word at PC is latched normally (instr_out<=imem_data, instr_valid<=1) even if stall=1; software supplies NOPs in the delay slot.
REQ-029 A branch edge with IFETCH_BRANCH_FLUSH_EN defined SHALL behave per REQ-027.
REQ-030 A branch edge without IFETCH_BRANCH_FLUSH_EN defined SHALL behave per REQ-028.

Verification
REQ-031 Reset with RESET_PC=0, memory word0=32'h180A0000, then 3 free-running edges -> imem_addr 0,4,8,12; pc_out 0,4,8; instr_out[0]=32'h180A0000; instr_valid=1 from the 1st edge.
REQ-032 stall=1 for 2 cycles at PC=16 -> imem_addr stays 16, instr_out/pc_out unchanged; resume -> pc_out=16, next PC=20.
REQ-033 branch_taken=1 with target 32'h90 at PC=32 -> next imem_addr=32'h90; flush build: instr_valid=0 and instr_out=0; non-flush build: instr_out=word@32 and instr_valid=1.
REQ-034 branch_taken=1 with stall=1 and target 32'h24 -> PC=32'h24 on the next edge; branch priority is confirmed.
REQ-035 branch_taken=1 with target 32'h93 -> PC=32'h90 and misalign_err=1 until reset, after which misalign_err=0.
REQ-036 PC=32'hFFFFFFFC with no branch and no stall -> next imem_addr=0; reset asserted mid-cycle -> outputs go to their reset values immediately, without waiting for a clock edge.
